pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline-control scheduler for the 5-stage RV32I core.
- Generates stage enables and bubble-insert flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Decodes register usage of the ID-stage instruction (same opcode classes the decode-stage immediate logic uses) and tracks EX/MEM/WB occupancy internally.
- Resolves load-use hazards, EX-resolved redirects, multi-cycle EX ops, data-memory wait states and FENCE/SYSTEM drains.

Parameters:
PERF_W, 32, width of the optional performance counters

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
id_instr  in  32  instruction held in IF/ID
id_valid  in  1  IF/ID holds a real instruction
ex_rd  in  5  destination register of the instruction in EX
ex_is_load  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved taken branch/JAL/JALR; PC must load the target
ex_busy  in  1  multi-cycle op in EX not finished
mem_req  in  1  MEM stage issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  load bubble (overrides enable)
ctrl_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 DRAIN, 3 STALL

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=RUN; internal valids v_ex, v_mem, v_wb = 0.
- While rst_n=0: all *_en=0, all *_flush=1.
- ID decode:
  - uses_rs1 for every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
  - uses_rs2 only for R-type 0110011, store 0100011 and branch 1100011.
  - is_drain for FENCE 0001111 and SYSTEM 1110011.
- Outputs are combinational from current inputs and valids. Apply the first matching rule, in this priority order:
  1. Freeze: mem_req & v_mem & !mem_ready → all en=0, flushes=0. Next state MEM_WAIT.
  2. Busy: ex_busy & v_ex → pc/ifid/idex en=0, exmem_flush=1, memwb_en=1. Next state STALL.
  3. Redirect: ex_redirect & v_ex → all en=1, ifid_flush=1, idex_flush=1. Next state RUN.
  4. Drain: id_valid & is_drain & (v_ex|v_mem|v_wb) → pc_en=0, ifid_en=0, idex_flush=1, others en=1. Next state DRAIN.
  5. Load-use: id_valid & ex_is_load & v_ex & ex_rd!=0 & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)) → same outputs as Drain. Next state STALL.
  6. Otherwise all en=1, flushes=0. Next state RUN.
- ctrl_state is the registered next state, i.e. it reflects the previous cycle's decision.
- Valid tracking on each rising clk:
  - v_ex ← idex_flush ? 0 : idex_en ? id_valid : v_ex.
  - v_mem ← exmem_flush ? 0 : exmem_en ? v_ex : v_mem.
  - v_wb ← memwb_en ? v_mem : v_wb.
- A redirect arriving during a freeze is not lost: EX is frozen, so it is acted on in the first unfrozen cycle.
- Load-use inserts exactly one bubble. The following cycle EX holds a bubble, so the hazard does not retrigger.
- rd=x0 never causes a hazard.
- A drain completes when v_ex, v_mem and v_wb are all 0. The FENCE/SYSTEM instruction then advances in that cycle.
- Reset asserted mid-stall or mid-freeze returns to RUN with empty valids immediately.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - adds outputs stall_cnt[PERF_W-1:0] and flush_cnt[PERF_W-1:0], both reset to 0.
  - stall_cnt increments every cycle pc_en=0 with rst_n=1.
  - flush_cnt increments on every Redirect cycle.
  - Both saturate at all-ones.
- Undefined: no counters, no extra ports, identical control behaviour.

Test Plan:
- Load-use: EX holds lw x5 (v_ex=1), ID holds add x6,x5,x7 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1. Repeat with rd=x0 → no stall.
- Non-hazard decode: EX holds lw x5, ID holds lui x5 or jal x5 → no stall; ID holds sw x5,0(x1) → stall (rs2 match).
- Redirect: ex_redirect=1 with v_ex=1 → ifid_flush=idex_flush=1, pc_en=1 for one cycle. Redirect coinciding with a load-use match → redirect wins, pc_en=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 pending → all en=0 for 3 cycles, ctrl_state=1; on mem_ready=1 the redirect flush fires.
- FENCE drain: fence in ID, v_ex=v_mem=v_wb=1 → 3 bubble cycles (ctrl_state=2), then fence advances. ex_busy for 4 cycles → exmem_flush=1, memwb_en=1 each of those cycles.
- Reset/perf: assert rst_n low mid-freeze → all en=0, flushes=1; release → RUN. With HAZARD_PERF_EN, after the load-use and drain sequences above, stall_cnt=4 and flush_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the core datapath and pipe_hazard_ctrl.
// master = datapath side, slave = hazard controller side.
interface pipe_hazard_ctrl_if;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_redirect;
    logic        ex_busy;
    logic        mem_req;
    logic        mem_ready;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        memwb_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        exmem_flush;

    modport master (
        output id_instr, id_valid, ex_rd, ex_is_load,
        output ex_redirect, ex_busy, mem_req, mem_ready,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, exmem_flush
    );

    modport slave (
        input  id_instr, id_valid, ex_rd, ex_is_load,
        input  ex_redirect, ex_busy, mem_req, mem_ready,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, exmem_flush
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32I pipeline.
// HAZARD_PERF_EN adds PERF_W and saturating stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
`ifdef HAZARD_PERF_EN
#(
    parameter int PERF_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus,
    output logic [1:0]        ctrl_state
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
`endif
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_MEM_WAIT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_STALL    = 2'd3;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0] op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_drain;
    logic       load_use;
    logic       redir_hit;
    logic [1:0] next_state;
    logic       v_ex;
    logic       v_mem;
    logic       v_wb;
    logic       unused_instr_bits;

    assign op  = bus.id_instr[6:0];
    assign rs1 = bus.id_instr[19:15];
    assign rs2 = bus.id_instr[24:20];
    assign unused_instr_bits = &{1'b0, bus.id_instr[31:25], bus.id_instr[14:7]};

    // Register-usage decode of the instruction sitting in IF/ID
    always_comb begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        is_drain = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL:      uses_rs1 = 1'b0;
            OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            OP_FENCE, OP_SYSTEM:           is_drain = 1'b1;
            default: ;
        endcase
    end

    // x0 destinations never create a dependency
    assign load_use = bus.id_valid & bus.ex_is_load & v_ex
                    & (bus.ex_rd != 5'd0)
                    & ((uses_rs1 & (rs1 == bus.ex_rd))
                     | (uses_rs2 & (rs2 == bus.ex_rd)));

    // Prioritised stall/flush decision; freeze outranks everything so a
    // pending redirect simply waits in the frozen EX stage
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.exmem_en    = 1'b1;
        bus.memwb_en    = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_flush  = 1'b0;
        bus.exmem_flush = 1'b0;
        next_state      = S_RUN;
        redir_hit       = 1'b0;
        if (!rst_n) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.memwb_en    = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_flush  = 1'b1;
            bus.exmem_flush = 1'b1;
        end else if (bus.mem_req & v_mem & !bus.mem_ready) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_en  = 1'b0;
            bus.exmem_en = 1'b0;
            bus.memwb_en = 1'b0;
            next_state   = S_MEM_WAIT;
        end else if (bus.ex_busy & v_ex) begin
            bus.pc_en       = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.exmem_en    = 1'b0;
            bus.exmem_flush = 1'b1;
            next_state      = S_STALL;
        end else if (bus.ex_redirect & v_ex) begin
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
            redir_hit      = 1'b1;
        end else if (bus.id_valid & is_drain & (v_ex | v_mem | v_wb)) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            next_state     = S_DRAIN;
        end else if (load_use) begin
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_flush = 1'b1;
            next_state     = S_STALL;
        end
    end

    // Record the decision and track which downstream stages hold real work
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_state <= S_RUN;
            v_ex       <= 1'b0;
            v_mem      <= 1'b0;
            v_wb       <= 1'b0;
        end else begin
            ctrl_state <= next_state;
            if (bus.idex_flush)
                v_ex <= 1'b0;
            else if (bus.idex_en)
                v_ex <= bus.id_valid;
            if (bus.exmem_flush)
                v_mem <= 1'b0;
            else if (bus.exmem_en)
                v_mem <= v_ex;
            if (bus.memwb_en)
                v_wb <= v_mem;
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating counts of stalled-fetch cycles and redirect flushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus.pc_en && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (redir_hit && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    logic unused_redir;
    assign unused_redir = redir_hit;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a rule-level model.
// Counter checks are active when HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    pipe_hazard_ctrl_if h();

    pipe_hazard_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(h),
        .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, state}
    wire [9:0] obs = {h.pc_en, h.ifid_en, h.idex_en, h.exmem_en,
                      h.memwb_en, h.ifid_flush, h.idex_flush,
                      h.exmem_flush, ctrl_state};

    int n_vec = 0;
    int n_bad = 0;

    // Model: occupancy of EX/MEM/WB, last decision, counters
    bit          m_vex, m_vmem, m_vwb;
    logic [1:0]  m_state, m_next;
    logic [9:0]  exp_vec;
    bit          m_redir;
    logic [31:0] m_stall, m_flush;

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [4:0] r1,
                                       input logic [4:0] r2,
                                       input logic [4:0] rd);
        return {7'd0, r2, r1, 3'd0, rd, op};
    endfunction

    function automatic void model_reset();
        m_vex = 0; m_vmem = 0; m_vwb = 0;
        m_state = 2'd0; m_stall = 0; m_flush = 0;
    endfunction

    function automatic void model_eval();
        logic [6:0] op;
        logic [4:0] r1, r2;
        logic [4:0] en;
        logic [2:0] fl;
        bit u1, u2, dr, lu;
        op = h.id_instr[6:0];
        r1 = h.id_instr[19:15];
        r2 = h.id_instr[24:20];
        u1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        dr = op inside {7'b0001111, 7'b1110011};
        lu = h.id_valid && h.ex_is_load && m_vex && h.ex_rd != 0
             && ((u1 && r1 == h.ex_rd) || (u2 && r2 == h.ex_rd));
        m_redir = 0;
        if (!rst_n) begin
            en = 5'b00000; fl = 3'b111; m_next = 0;
        end else if (h.mem_req && m_vmem && !h.mem_ready) begin
            en = 5'b00000; fl = 3'b000; m_next = 1;
        end else if (h.ex_busy && m_vex) begin
            en = 5'b00001; fl = 3'b001; m_next = 3;
        end else if (h.ex_redirect && m_vex) begin
            en = 5'b11111; fl = 3'b110; m_next = 0; m_redir = 1;
        end else if (h.id_valid && dr && (m_vex || m_vmem || m_vwb)) begin
            en = 5'b00111; fl = 3'b010; m_next = 2;
        end else if (lu) begin
            en = 5'b00111; fl = 3'b010; m_next = 3;
        end else begin
            en = 5'b11111; fl = 3'b000; m_next = 0;
        end
        exp_vec = {en, fl, m_state};
    endfunction

    function automatic void model_tick();
        bit nex, nmem, nwb;
        if (!rst_n) begin
            model_reset();
        end else begin
            nex  = exp_vec[3] ? 1'b0 : exp_vec[7] ? h.id_valid : m_vex;
            nmem = exp_vec[2] ? 1'b0 : exp_vec[6] ? m_vex : m_vmem;
            nwb  = exp_vec[5] ? m_vmem : m_vwb;
            m_vex = nex; m_vmem = nmem; m_vwb = nwb;
            m_state = m_next;
            if (!exp_vec[9] && m_stall != '1) m_stall++;
            if (m_redir && m_flush != '1) m_flush++;
        end
    endfunction

    task automatic quiet_inputs();
        h.id_instr = mk(7'h13, 0, 0, 0);
        h.id_valid = 1; h.ex_rd = 0; h.ex_is_load = 0;
        h.ex_redirect = 0; h.ex_busy = 0;
        h.mem_req = 0; h.mem_ready = 1;
    endtask

    task automatic fill_pipe();
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL fill c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== 10'b00000_111_00) begin
                n_bad++;
                $display("FAIL reset c%0d got=%b exp=%b", i, obs, 10'b00000_111_00);
            end
            @(posedge clk); model_tick(); #1;
        end
        rst_n = 1;
        @(negedge clk); model_eval(); n_vec++;
        if (obs !== 10'b11111_000_00 || obs !== exp_vec) begin
            n_bad++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp_vec);
        end
        @(posedge clk); model_tick(); #1;
    endtask

    task automatic test_load_use(input logic [4:0] rd);
        fill_pipe();
        h.ex_is_load = 1; h.ex_rd = rd;
        h.id_instr = mk(7'h33, rd, 7, 6);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec
                || h.pc_en !== ((rd != 0 && i == 0) ? 1'b0 : 1'b1)) begin
                n_bad++;
                $display("FAIL load_use rd%0d c%0d got=%b exp=%b",
                         rd, i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_decode();
        logic [31:0] ins [3];
        logic        stall [3];
        ins[0] = mk(7'h37, 5, 5, 5); stall[0] = 0;
        ins[1] = mk(7'h6f, 5, 5, 5); stall[1] = 0;
        ins[2] = mk(7'h23, 1, 5, 0); stall[2] = 1;
        for (int k = 0; k < 3; k++) begin
            fill_pipe();
            h.ex_is_load = 1; h.ex_rd = 5; h.id_instr = ins[k];
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec || h.pc_en !== !stall[k]) begin
                n_bad++;
                $display("FAIL decode k%0d got=%b exp=%b", k, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_redirect(input bit with_hazard);
        fill_pipe();
        h.ex_redirect = 1;
        if (with_hazard) begin
            h.ex_is_load = 1; h.ex_rd = 5;
            h.id_instr = mk(7'h33, 5, 7, 6);
        end
        @(negedge clk); model_eval(); n_vec++;
        if (obs !== exp_vec || h.pc_en !== 1'b1
            || h.ifid_flush !== 1'b1 || h.idex_flush !== 1'b1) begin
            n_bad++;
            $display("FAIL redirect h%0d got=%b exp=%b", with_hazard, obs, exp_vec);
        end
        @(posedge clk); model_tick(); #1;
        quiet_inputs();
    endtask

    task automatic test_mem_wait();
        fill_pipe();
        h.mem_req = 1; h.mem_ready = 0; h.ex_redirect = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) h.mem_ready = 1;
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec
                || (i < 3 && obs[9:5] !== 5'b00000)
                || (i > 0 && ctrl_state !== 2'd1)
                || (i == 3 && obs[4:3] !== 2'b11)) begin
                n_bad++;
                $display("FAIL mem_wait c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_drain();
        fill_pipe();
        h.id_instr = mk(7'h0f, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec
                || h.pc_en !== (i == 3)
                || h.idex_flush !== (i < 3)
                || (i > 0 && ctrl_state !== 2'd2)) begin
                n_bad++;
                $display("FAIL drain c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_busy();
        fill_pipe();
        h.ex_busy = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec || h.exmem_flush !== 1'b1
                || h.memwb_en !== 1'b1 || h.pc_en !== 1'b0) begin
                n_bad++;
                $display("FAIL busy c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_reset_mid_freeze();
        fill_pipe();
        h.mem_req = 1; h.mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL freeze c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        #3 rst_n = 0;
        #1;
        model_reset();
        n_vec++;
        if (obs !== 10'b00000_111_00) begin
            n_bad++;
            $display("FAIL async_reset got=%b exp=%b", obs, 10'b00000_111_00);
        end
        @(posedge clk); #1;
        h.mem_req = 0; h.mem_ready = 1;
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec || ctrl_state !== 2'd0) begin
                n_bad++;
                $display("FAIL post_reset c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
        ops[4] = 7'h63; ops[5] = 7'h37; ops[6] = 7'h17; ops[7] = 7'h6f;
        ops[8] = ($urandom_range(1) != 0) ? 7'h0f : 7'h73;
        for (int i = 0; i < 400; i++) begin
            h.id_instr = mk(ops[$urandom_range(8)],
                            5'($urandom_range(3)), 5'($urandom_range(3)),
                            5'($urandom_range(31)));
            h.id_valid    = ($urandom_range(7) != 0);
            h.ex_rd       = 5'($urandom_range(3));
            h.ex_is_load  = ($urandom_range(2) == 0);
            h.ex_redirect = ($urandom_range(5) == 0);
            h.ex_busy     = ($urandom_range(6) == 0);
            h.mem_req     = ($urandom_range(2) == 0);
            h.mem_ready   = ($urandom_range(3) != 0);
            @(negedge clk); model_eval(); n_vec++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL random c%0d got=%b exp=%b", i, obs, exp_vec);
            end
            @(posedge clk); model_tick(); #1;
        end
        quiet_inputs();
    endtask

    task automatic test_perf();
        rst_n = 0;
        quiet_inputs();
        @(negedge clk); model_eval();
        @(posedge clk); model_tick(); #1;
        rst_n = 1;
        test_load_use(5'd5);
        test_redirect(1'b0);
        test_drain();
`ifdef HAZARD_PERF_EN
        n_vec++;
        if (stall_cnt !== 32'd4 || stall_cnt !== m_stall) begin
            n_bad++;
            $display("FAIL stall_cnt got=%0d exp=4 model=%0d", stall_cnt, m_stall);
        end
        n_vec++;
        if (flush_cnt !== 32'd1 || flush_cnt !== m_flush) begin
            n_bad++;
            $display("FAIL flush_cnt got=%0d exp=1 model=%0d", flush_cnt, m_flush);
        end
`endif
    endtask

    initial begin
        quiet_inputs();
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_load_use(5'd5);
        test_load_use(5'd0);
        test_decode();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_mem_wait();
        test_drain();
        test_busy();
        test_reset_mid_freeze();
        test_random();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
